instr_ctrl_unit: RTL and testbench

Multi-cycle instruction control unit for the 8-bit processor. It sits directly upstream of the 8x8 register file. It fetches 32-bit instructions from instruction memory through a request/valid handshake, decodes them, and drives the register-file read/write addresses, the immediate value, the ALU operation select and the write-enable. It sequences each instruction through fixed DECODE/EXEC/WB cycles and owns the program counter, including jump and branch-if-equal.

---
 rtl/instr_ctrl_unit_if.sv | 30 +++
 rtl/instr_ctrl_unit.sv | 151 +++++++++++++++
 tb/tb_instr_ctrl_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/instr_ctrl_unit_if.sv
// Fetch/decode bus between the instruction control unit and the instruction
// memory, register file and ALU that surround it.
interface instr_ctrl_unit_if;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        ZERO;
    logic [7:0]  PC;
    logic        FETCH_REQ;
    logic [2:0]  INaddr;
    logic [2:0]  OUT1addr;
    logic [2:0]  OUT2addr;
    logic [7:0]  IMM;
    logic        IMM_SEL;
    logic [2:0]  ALU_SEL;
    logic        WR_EN;
    logic        HALTED;
    logic        ILLEGAL;

    modport master (
        input  INSTR, INSTR_VALID, ZERO,
        output PC, FETCH_REQ, INaddr, OUT1addr, OUT2addr, IMM, IMM_SEL,
               ALU_SEL, WR_EN, HALTED, ILLEGAL
    );

    modport slave (
        output INSTR, INSTR_VALID, ZERO,
        input  PC, FETCH_REQ, INaddr, OUT1addr, OUT2addr, IMM, IMM_SEL,
               ALU_SEL, WR_EN, HALTED, ILLEGAL
    );
endinterface

// File: rtl/instr_ctrl_unit.sv
// Multi-cycle instruction control unit: fetches, decodes and sequences each
// instruction through DECODE/EXEC/WB and owns the program counter.
module instr_ctrl_unit (
    input  logic              CLK,
    input  logic              RESET,
    instr_ctrl_unit_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;

    logic [2:0] state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] op_q;
    logic [7:0] br_off_q;
    logic [2:0] in_addr_q, out1_addr_q, out2_addr_q;
    logic [7:0] imm_q;
    logic       imm_sel_q;
    logic [2:0] alu_sel_q;
    logic       wr_op_q;
    logic       zero_q;
    logic       fetch_req_q, wr_en_q, halted_q, illegal_q;

    logic [7:0] dec_op;
    logic [2:0] dec_alu_sel;
    logic       dec_imm_sel, dec_wr_op, dec_illegal;
    logic       accept;

    assign dec_op = bus.INSTR[31:24];
    assign accept = (state_q == S_FETCH) && bus.INSTR_VALID;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        dec_alu_sel = ALU_FWD;
        dec_imm_sel = 1'b0;
        dec_wr_op   = 1'b0;
        dec_illegal = 1'b0;
        case (dec_op)
            OP_LOADI: begin dec_imm_sel = 1'b1; dec_wr_op = 1'b1; end
            OP_MOV:   dec_wr_op = 1'b1;
            OP_ADD:   begin dec_alu_sel = ALU_ADD; dec_wr_op = 1'b1; end
            OP_SUB:   begin dec_alu_sel = ALU_SUB; dec_wr_op = 1'b1; end
            OP_AND:   begin dec_alu_sel = ALU_AND; dec_wr_op = 1'b1; end
            OP_OR:    begin dec_alu_sel = ALU_OR;  dec_wr_op = 1'b1; end
            OP_J:     ;
            OP_BEQ:   dec_alu_sel = ALU_SUB;
            OP_HALT:  ;
            default:  dec_illegal = 1'b1;
        endcase
    end

    // Offsets are 8-bit two's complement, so sign extension to the 8-bit PC
    // is the identity and the sum wraps modulo 256.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.INSTR_VALID) state_d = S_DECODE;
            S_DECODE: state_d = (op_q == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_J:    pc_d = pc_q + 8'd1 + imm_q;
                    OP_BEQ:  pc_d = zero_q ? (pc_q + 8'd1 + br_off_q) : (pc_q + 8'd1);
                    default: pc_d = pc_q + 8'd1;
                endcase
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            pc_q        <= 8'd0;
            op_q        <= 8'd0;
            br_off_q    <= 8'd0;
            in_addr_q   <= 3'd0;
            out1_addr_q <= 3'd0;
            out2_addr_q <= 3'd0;
            imm_q       <= 8'd0;
            imm_sel_q   <= 1'b0;
            alu_sel_q   <= ALU_FWD;
            wr_op_q     <= 1'b0;
            zero_q      <= 1'b0;
            fetch_req_q <= 1'b0;
            wr_en_q     <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_req_q <= (state_d == S_FETCH);
            wr_en_q     <= (state_d == S_WB) && wr_op_q;
            halted_q    <= halted_q | (state_d == S_HALT);
            if (state_q == S_EXEC)
                zero_q <= bus.ZERO;
            if (accept) begin
                op_q        <= dec_op;
                br_off_q    <= bus.INSTR[23:16];
                in_addr_q   <= bus.INSTR[18:16];
                out1_addr_q <= bus.INSTR[10:8];
                out2_addr_q <= bus.INSTR[2:0];
                imm_q       <= bus.INSTR[7:0];
                imm_sel_q   <= dec_imm_sel;
                alu_sel_q   <= dec_alu_sel;
                wr_op_q     <= dec_wr_op;
                illegal_q   <= illegal_q | dec_illegal;
            end
        end
    end

    assign bus.PC        = pc_q;
    assign bus.FETCH_REQ = fetch_req_q;
    assign bus.INaddr    = in_addr_q;
    assign bus.OUT1addr  = out1_addr_q;
    assign bus.OUT2addr  = out2_addr_q;
    assign bus.IMM       = imm_q;
    assign bus.IMM_SEL   = imm_sel_q;
    assign bus.ALU_SEL   = alu_sel_q;
    assign bus.WR_EN     = wr_en_q;
    assign bus.HALTED    = halted_q;
    assign bus.ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_instr_ctrl_unit.sv
// Directed bench for instr_ctrl_unit: instruction sequences with hand-computed
// PC, decode, write-strobe, halt, illegal and asynchronous-reset expectations.
module tb_instr_ctrl_unit;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    instr_ctrl_unit_if bus ();

    instr_ctrl_unit dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge with the unit in FETCH; leaves it at the
    // falling edge inside DECODE.
    task automatic issue(input logic [31:0] instr, input int stall, input logic [7:0] pc_exp);
        for (int i = 0; i < stall; i++) begin
            bus.INSTR_VALID = 1'b0;
            bus.INSTR       = instr;
            @(negedge clk);
            check("stall_req", bus.FETCH_REQ, 1);
            check("stall_pc", bus.PC, pc_exp);
            check("stall_wr", bus.WR_EN, 0);
        end
        bus.INSTR       = instr;
        bus.INSTR_VALID = 1'b1;
        @(negedge clk);
        bus.INSTR_VALID = 1'b0;
        check("dec_req", bus.FETCH_REQ, 0);
        check("dec_pc", bus.PC, pc_exp);
    endtask

    // From DECODE: walk EXEC and WB, ending at the falling edge in FETCH.
    task automatic retire(input logic zero, input logic wr_exp,
                          input logic [7:0] pc_old, input logic [7:0] pc_new);
        check("dec_wr", bus.WR_EN, 0);
        @(negedge clk);
        bus.ZERO = zero;
        check("exec_wr", bus.WR_EN, 0);
        check("exec_pc", bus.PC, pc_old);
        @(negedge clk);
        bus.ZERO = 1'b0;
        check("wb_wr", bus.WR_EN, wr_exp);
        check("wb_pc", bus.PC, pc_old);
        @(negedge clk);
        check("next_wr", bus.WR_EN, 0);
        check("next_req", bus.FETCH_REQ, 1);
        check("next_pc", bus.PC, pc_new);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_pc"}, bus.PC, 0);
        check({tag, "_req"}, bus.FETCH_REQ, 0);
        check({tag, "_in"}, bus.INaddr, 0);
        check({tag, "_o1"}, bus.OUT1addr, 0);
        check({tag, "_o2"}, bus.OUT2addr, 0);
        check({tag, "_imm"}, bus.IMM, 0);
        check({tag, "_isel"}, bus.IMM_SEL, 0);
        check({tag, "_alu"}, bus.ALU_SEL, 0);
        check({tag, "_wr"}, bus.WR_EN, 0);
        check({tag, "_halt"}, bus.HALTED, 0);
        check({tag, "_ill"}, bus.ILLEGAL, 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.INSTR       = 32'h0002_0016;
        bus.INSTR_VALID = 1'b1;
        bus.ZERO        = 1'b0;
        #2;
        check_cleared("rst");

        // loadi held valid through IDLE; accepted on the first FETCH edge
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_req", bus.FETCH_REQ, 0);
        @(negedge clk);
        check("fetch_req", bus.FETCH_REQ, 1);
        check("fetch_in", bus.INaddr, 0);
        @(negedge clk);
        bus.INSTR_VALID = 1'b0;
        check("loadi_in", bus.INaddr, 2);
        check("loadi_imm", bus.IMM, 8'h16);
        check("loadi_isel", bus.IMM_SEL, 1);
        check("loadi_alu", bus.ALU_SEL, 3'b000);
        retire(1'b0, 1'b1, 8'd0, 8'd1);

        // add with three stall cycles in FETCH
        issue(32'h0203_0104, 3, 8'd1);
        check("add_o1", bus.OUT1addr, 1);
        check("add_o2", bus.OUT2addr, 4);
        check("add_in", bus.INaddr, 3);
        check("add_alu", bus.ALU_SEL, 3'b001);
        check("add_isel", bus.IMM_SEL, 0);
        retire(1'b0, 1'b1, 8'd1, 8'd2);

        // j +2 from PC 2 lands on 5
        issue(32'h0600_0002, 0, 8'd2);
        retire(1'b0, 1'b0, 8'd2, 8'd5);

        // beq taken, offset -2: 5 + 1 - 2 = 4
        issue(32'h07FE_0000, 0, 8'd5);
        check("beq_alu", bus.ALU_SEL, 3'b100);
        retire(1'b1, 1'b0, 8'd5, 8'd4);

        issue(32'h0600_0000, 0, 8'd4);
        retire(1'b0, 1'b0, 8'd4, 8'd5);

        // beq not taken
        issue(32'h07FE_0000, 0, 8'd5);
        retire(1'b0, 1'b0, 8'd5, 8'd6);

        // 6 + 1 + 0xF7 = 254, then 254 + 1 + 3 wraps to 2
        issue(32'h0600_00F7, 0, 8'd6);
        retire(1'b0, 1'b0, 8'd6, 8'd254);
        issue(32'h0600_0003, 0, 8'd254);
        retire(1'b0, 1'b0, 8'd254, 8'd2);

        // undefined opcode
        issue(32'h0900_0000, 0, 8'd2);
        check("ill_set", bus.ILLEGAL, 1);
        retire(1'b0, 1'b0, 8'd2, 8'd3);

        // mov; ILLEGAL must stay set
        issue(32'h0105_0600, 0, 8'd3);
        check("mov_in", bus.INaddr, 5);
        check("mov_o1", bus.OUT1addr, 6);
        check("mov_alu", bus.ALU_SEL, 3'b000);
        retire(1'b0, 1'b1, 8'd3, 8'd4);
        check("ill_sticky", bus.ILLEGAL, 1);

        // halt: frozen even with a valid instruction presented
        issue(32'hFF00_0000, 0, 8'd4);
        check("halt_pre", bus.HALTED, 0);
        bus.INSTR       = 32'h0203_0104;
        bus.INSTR_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_flag", bus.HALTED, 1);
            check("halt_req", bus.FETCH_REQ, 0);
            check("halt_wr", bus.WR_EN, 0);
            check("halt_pc", bus.PC, 4);
        end
        bus.INSTR_VALID = 1'b0;

        // reset clears halt and sticky ILLEGAL
        rst = 1'b1;
        #1;
        check_cleared("rst2");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst2_fetch", bus.FETCH_REQ, 1);

        // reset asserted mid-WB of an add cancels the write asynchronously
        issue(32'h0203_0104, 0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        check("midwb_wr", bus.WR_EN, 1);
        #1;
        rst = 1'b1;
        #1;
        check_cleared("midwb");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_idle", bus.FETCH_REQ, 0);
        @(negedge clk);
        check("post_req", bus.FETCH_REQ, 1);
        check("post_pc", bus.PC, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
